io_port_fx: RTL and testbench

Processor-side I/O responder for the fixed-point stack core. It serves the `req_in` strobe issued by the decoder for IN and the `out_en` strobe issued for OUT. Each direction has its own FIFO with a valid/ready handshake toward external logic, and the block returns a `stall` that freezes the core while the requested transfer cannot complete.

---
 rtl/io_port_fx.sv | 147 ++++++++++++++
 tb/tb_io_port_fx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_fx.sv
// IN/OUT responder: one FIFO per direction plus a core stall.
// Optional feature macro IO_BYPASS_EN forwards ext_in_data on an IN to an empty input FIFO.
module io_port_fx #(
    parameter int NBDATA = 32,
    parameter int IDEPTH = 4,
    parameter int ODEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    output logic [NBDATA-1:0]        io_in,
    input  logic                     out_en,
    input  logic [NBDATA-1:0]        out_data,
    output logic                     stall,
    input  logic [NBDATA-1:0]        ext_in_data,
    input  logic                     ext_in_valid,
    output logic                     ext_in_ready,
    output logic [NBDATA-1:0]        ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    output logic [$clog2(IDEPTH):0]  in_level,
    output logic [$clog2(ODEPTH):0]  out_level
);

    localparam int IAW = $clog2(IDEPTH);
    localparam int OAW = $clog2(ODEPTH);
    localparam int ILW = IAW + 1;
    localparam int OLW = OAW + 1;
    localparam logic [ILW-1:0] IFULL = ILW'(IDEPTH);
    localparam logic [OLW-1:0] OFULL = OLW'(ODEPTH);

    // Handshake: a word moves on a rising edge where valid and ready are both high.
    // ready never looks at the partner's valid, except that a bypass forces ext_in_ready.

    logic              run_q, run_d;
    logic [NBDATA-1:0] in_mem_q [IDEPTH];
    logic [NBDATA-1:0] in_mem_d [IDEPTH];
    logic [IAW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [ILW-1:0]    in_lvl_q, in_lvl_d;
    logic [NBDATA-1:0] out_mem_q [ODEPTH];
    logic [NBDATA-1:0] out_mem_d [ODEPTH];
    logic [OAW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [OLW-1:0]    out_lvl_q, out_lvl_d;

    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;
    logic bypass_hit;

    assign in_empty  = (in_lvl_q == '0);
    assign in_full   = (in_lvl_q == IFULL);
    assign out_empty = (out_lvl_q == '0);
    assign out_full  = (out_lvl_q == OFULL);

`ifdef IO_BYPASS_EN
    assign bypass_hit = run_q & req_in & in_empty & ext_in_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // run_q holds every handshake and the stall low until the first edge after reset.
    assign run_d        = 1'b1;
    assign ext_in_ready = run_q & (!in_full | bypass_hit);
    assign in_push      = ext_in_valid & ext_in_ready & !bypass_hit;
    assign in_pop       = req_in & !in_empty;
    assign out_push     = run_q & out_en & !out_full;
    assign out_pop      = ext_out_ready & !out_empty;

    always_comb begin
        in_mem_d = in_mem_q;
        in_wr_d  = in_wr_q;
        in_rd_d  = in_rd_q;
        in_lvl_d = in_lvl_q;
        if (in_push) begin
            in_mem_d[in_wr_q] = ext_in_data;
            in_wr_d           = in_wr_q + IAW'(1);
        end
        if (in_pop) begin
            in_rd_d = in_rd_q + IAW'(1);
        end
        case ({in_push, in_pop})
            2'b10:   in_lvl_d = in_lvl_q + ILW'(1);
            2'b01:   in_lvl_d = in_lvl_q - ILW'(1);
            default: in_lvl_d = in_lvl_q;
        endcase
    end

    always_comb begin
        out_mem_d = out_mem_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_lvl_d = out_lvl_q;
        if (out_push) begin
            out_mem_d[out_wr_q] = out_data;
            out_wr_d            = out_wr_q + OAW'(1);
        end
        if (out_pop) begin
            out_rd_d = out_rd_q + OAW'(1);
        end
        case ({out_push, out_pop})
            2'b10:   out_lvl_d = out_lvl_q + OLW'(1);
            2'b01:   out_lvl_d = out_lvl_q - OLW'(1);
            default: out_lvl_d = out_lvl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q     <= 1'b0;
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            in_lvl_q  <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_lvl_q <= '0;
            for (int i = 0; i < IDEPTH; i++) in_mem_q[i] <= '0;
            for (int i = 0; i < ODEPTH; i++) out_mem_q[i] <= '0;
        end else begin
            run_q     <= run_d;
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            in_lvl_q  <= in_lvl_d;
            in_mem_q  <= in_mem_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            out_lvl_q <= out_lvl_d;
            out_mem_q <= out_mem_d;
        end
    end

    // A full output FIFO stalls regardless of ext_out_ready, keeping that input off the stall path.
    assign stall = run_q & ((req_in & in_empty & !bypass_hit) | (out_en & out_full));

    always_comb begin
        io_in = '0;
        if (bypass_hit) begin
            io_in = ext_in_data;
        end else if (!in_empty) begin
            io_in = in_mem_q[in_rd_q];
        end
    end

    assign ext_out_data  = out_empty ? '0 : out_mem_q[out_rd_q];
    assign ext_out_valid = !out_empty;
    assign in_level      = in_lvl_q;
    assign out_level     = out_lvl_q;

endmodule

// File: tb/tb_io_port_fx.sv
// Self-checking bench for io_port_fx: scenario tasks with a queue-based scoreboard per direction.
// Honours IO_BYPASS_EN when the same macro is defined for the build.
module tb_io_port_fx;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_in, out_en, ext_in_valid, ext_out_ready;
    logic [NB-1:0] out_data, ext_in_data;
    logic [NB-1:0] io_in, ext_out_data;
    logic          stall, ext_in_ready, ext_out_valid;
    logic [2:0]    in_level, out_level;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [NB-1:0] in_q[$];
    logic [NB-1:0] out_q[$];

    always #5 clk = ~clk;

    io_port_fx #(.NBDATA(NB), .IDEPTH(4), .ODEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_in(req_in), .io_in(io_in),
        .out_en(out_en), .out_data(out_data), .stall(stall),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .in_level(in_level), .out_level(out_level)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        req_in = 1'b0; out_en = 1'b0; ext_in_valid = 1'b0; ext_out_ready = 1'b0;
        out_data = '0; ext_in_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            req_in = 1'($urandom_range(0, 1)); out_en = 1'($urandom_range(0, 1));
            ext_in_valid = 1'($urandom_range(0, 1)); ext_out_ready = 1'($urandom_range(0, 1));
            out_data = $urandom; ext_in_data = $urandom;
            settle();
            total_cnt++; if (io_in !== '0) $display("FAIL reset_io_in got=%h exp=0", io_in); else pass_cnt++;
            total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else pass_cnt++;
            total_cnt++; if (ext_in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", ext_in_ready); else pass_cnt++;
            total_cnt++; if (ext_out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", ext_out_valid); else pass_cnt++;
            total_cnt++; if (ext_out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", ext_out_data); else pass_cnt++;
            total_cnt++; if (in_level !== 3'd0) $display("FAIL reset_in_level got=%0d exp=0", in_level); else pass_cnt++;
            total_cnt++; if (out_level !== 3'd0) $display("FAIL reset_out_level got=%0d exp=0", out_level); else pass_cnt++;
        end
        tick();
        idle_inputs();
        rst = 1'b1;
        settle();
        tick();
        settle();
        total_cnt++; if (ext_in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", ext_in_ready); else pass_cnt++;
        total_cnt++; if (in_level !== 3'd0) $display("FAIL release_in_level got=%0d exp=0", in_level); else pass_cnt++;
        total_cnt++; if (out_level !== 3'd0) $display("FAIL release_out_level got=%0d exp=0", out_level); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL release_stall got=%b exp=0", stall); else pass_cnt++;
    endtask

    task automatic test_in_order();
        logic [NB-1:0] words [3];
        logic [NB-1:0] exp;
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            ext_in_valid = 1'b1; ext_in_data = words[i];
            settle();
            total_cnt++; if (ext_in_ready !== 1'b1) $display("FAIL order_in_ready got=%b exp=1", ext_in_ready); else pass_cnt++;
            in_q.push_back(ext_in_data);
        end
        tick();
        ext_in_valid = 1'b0;
        settle();
        total_cnt++; if (in_level !== 3'd3) $display("FAIL order_level_full got=%0d exp=3", in_level); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            req_in = 1'b1;
            settle();
            exp = in_q.pop_front();
            total_cnt++; if (stall !== 1'b0) $display("FAIL order_stall got=%b exp=0", stall); else pass_cnt++;
            total_cnt++; if (io_in !== exp) $display("FAIL order_io_in got=%h exp=%h", io_in, exp); else pass_cnt++;
        end
        tick();
        req_in = 1'b0;
        settle();
        total_cnt++; if (in_level !== 3'd0) $display("FAIL order_level_empty got=%0d exp=0", in_level); else pass_cnt++;
        total_cnt++; if (io_in !== '0) $display("FAIL order_io_in_empty got=%h exp=0", io_in); else pass_cnt++;
    endtask

    task automatic test_in_empty_stall();
        logic [NB-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            tick();
            req_in = 1'b1;
            settle();
            total_cnt++; if (stall !== 1'b1) $display("FAIL empty_stall_wait got=%b exp=1", stall); else pass_cnt++;
            total_cnt++; if (io_in !== '0) $display("FAIL empty_io_in_wait got=%h exp=0", io_in); else pass_cnt++;
        end
        tick();
        ext_in_valid = 1'b1; ext_in_data = 32'hABCD;
        in_q.push_back(ext_in_data);
        settle();
`ifdef IO_BYPASS_EN
        exp = in_q.pop_front();
        total_cnt++; if (stall !== 1'b0) $display("FAIL bypass_stall got=%b exp=0", stall); else pass_cnt++;
        total_cnt++; if (io_in !== exp) $display("FAIL bypass_io_in got=%h exp=%h", io_in, exp); else pass_cnt++;
        total_cnt++; if (ext_in_ready !== 1'b1) $display("FAIL bypass_ready got=%b exp=1", ext_in_ready); else pass_cnt++;
        tick();
        req_in = 1'b0; ext_in_valid = 1'b0;
        settle();
`else
        total_cnt++; if (stall !== 1'b1) $display("FAIL empty_stall_write got=%b exp=1", stall); else pass_cnt++;
        tick();
        ext_in_valid = 1'b0;
        settle();
        exp = in_q.pop_front();
        total_cnt++; if (stall !== 1'b0) $display("FAIL empty_stall_drop got=%b exp=0", stall); else pass_cnt++;
        total_cnt++; if (io_in !== exp) $display("FAIL empty_io_in got=%h exp=%h", io_in, exp); else pass_cnt++;
        tick();
        req_in = 1'b0;
        settle();
`endif
        total_cnt++; if (in_level !== 3'd0) $display("FAIL empty_level_after got=%0d exp=0", in_level); else pass_cnt++;
    endtask

    task automatic test_out_full();
        logic [NB-1:0] exp;
        ext_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            out_en = 1'b1; out_data = NB'(i);
            settle();
            total_cnt++; if (stall !== 1'b0) $display("FAIL full_push_stall got=%b exp=0", stall); else pass_cnt++;
            out_q.push_back(out_data);
        end
        tick();
        out_data = 32'd5;
        settle();
        total_cnt++; if (stall !== 1'b1) $display("FAIL full_stall got=%b exp=1", stall); else pass_cnt++;
        total_cnt++; if (out_level !== 3'd4) $display("FAIL full_level got=%0d exp=4", out_level); else pass_cnt++;
        total_cnt++; if (ext_out_valid !== 1'b1) $display("FAIL full_valid got=%b exp=1", ext_out_valid); else pass_cnt++;
        tick();
        ext_out_ready = 1'b1;
        settle();
        exp = out_q.pop_front();
        total_cnt++; if (stall !== 1'b1) $display("FAIL full_stall_ready got=%b exp=1", stall); else pass_cnt++;
        total_cnt++; if (ext_out_data !== exp) $display("FAIL full_drain got=%h exp=%h", ext_out_data, exp); else pass_cnt++;
        tick();
        settle();
        exp = out_q.pop_front();
        total_cnt++; if (stall !== 1'b0) $display("FAIL full_stall_drop got=%b exp=0", stall); else pass_cnt++;
        total_cnt++; if (ext_out_data !== exp) $display("FAIL full_drain got=%h exp=%h", ext_out_data, exp); else pass_cnt++;
        out_q.push_back(out_data);
        for (int n = 0; n < 10 && out_q.size() > 0; n++) begin
            tick();
            out_en = 1'b0;
            settle();
            exp = out_q.pop_front();
            total_cnt++;
            if (ext_out_valid !== 1'b1 || ext_out_data !== exp)
                $display("FAIL full_drain got=%h valid=%b exp=%h", ext_out_data, ext_out_valid, exp);
            else pass_cnt++;
        end
        tick();
        ext_out_ready = 1'b0;
        settle();
        total_cnt++; if (out_level !== 3'd0) $display("FAIL full_level_end got=%0d exp=0", out_level); else pass_cnt++;
        total_cnt++; if (ext_out_valid !== 1'b0) $display("FAIL full_valid_end got=%b exp=0", ext_out_valid); else pass_cnt++;
    endtask

    task automatic test_wrap_concurrency();
        int sent = 0, rcvd = 0, opushed = 0, odrained = 0, cyc = 0;
        int lvl, lvlo, r;
        logic byp, exp_in_stall, exp_out_stall;
        logic [NB-1:0] exp;
        while (!(rcvd == 20 && odrained == 20) && cyc < 2000) begin
            cyc++;
            tick();
            r = $urandom_range(0, 2);
            req_in = (r == 0) && (rcvd < 20);
            out_en = (r == 1) && (opushed < 20);
            ext_in_valid = (sent < 20) && ($urandom_range(0, 1) == 1);
            ext_in_data = $urandom; out_data = $urandom;
            ext_out_ready = 1'($urandom_range(0, 1));
            settle();
            lvl = in_q.size();
            lvlo = out_q.size();
            byp = 1'b0;
`ifdef IO_BYPASS_EN
            byp = req_in && ext_in_valid && (lvl == 0);
`endif
            exp_in_stall = req_in && (lvl == 0) && !byp;
            exp_out_stall = out_en && (lvlo == 4);
            total_cnt++; if (in_level !== 3'(lvl)) $display("FAIL wrap_in_level got=%0d exp=%0d", in_level, lvl); else pass_cnt++;
            total_cnt++; if (out_level !== 3'(lvlo)) $display("FAIL wrap_out_level got=%0d exp=%0d", out_level, lvlo); else pass_cnt++;
            total_cnt++; if (stall !== (exp_in_stall || exp_out_stall)) $display("FAIL wrap_stall got=%b exp=%b", stall, exp_in_stall || exp_out_stall); else pass_cnt++;
            total_cnt++; if (ext_in_ready !== (lvl < 4)) $display("FAIL wrap_in_ready got=%b exp=%b", ext_in_ready, lvl < 4); else pass_cnt++;
            total_cnt++; if (ext_out_valid !== (lvlo > 0)) $display("FAIL wrap_out_valid got=%b exp=%b", ext_out_valid, lvlo > 0); else pass_cnt++;
            if (ext_in_valid && lvl < 4) begin
                in_q.push_back(ext_in_data);
                sent++;
            end
            if (req_in && !exp_in_stall) begin
                exp = in_q.pop_front();
                rcvd++;
                total_cnt++; if (io_in !== exp) $display("FAIL wrap_io_in got=%h exp=%h", io_in, exp); else pass_cnt++;
            end
            if (lvlo > 0) begin
                total_cnt++; if (ext_out_data !== out_q[0]) $display("FAIL wrap_out_data got=%h exp=%h", ext_out_data, out_q[0]); else pass_cnt++;
                if (ext_out_ready) begin
                    void'(out_q.pop_front());
                    odrained++;
                end
            end
            if (out_en && lvlo < 4) begin
                out_q.push_back(out_data);
                opushed++;
            end
        end
        total_cnt++;
        if (rcvd != 20 || odrained != 20)
            $display("FAIL wrap_timeout got rcvd=%0d drained=%0d exp 20/20", rcvd, odrained);
        else pass_cnt++;
        tick();
        idle_inputs();
        settle();
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            tick();
            ext_in_valid = 1'b1; ext_in_data = NB'(32'h100 + i);
            out_en = 1'b1; out_data = NB'(32'h200 + i);
            settle();
        end
        tick();
        idle_inputs();
        settle();
        total_cnt++; if (in_level !== 3'd3) $display("FAIL mid_in_level_pre got=%0d exp=3", in_level); else pass_cnt++;
        total_cnt++; if (out_level !== 3'd3) $display("FAIL mid_out_level_pre got=%0d exp=3", out_level); else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        total_cnt++; if (in_level !== 3'd0) $display("FAIL mid_in_level got=%0d exp=0", in_level); else pass_cnt++;
        total_cnt++; if (out_level !== 3'd0) $display("FAIL mid_out_level got=%0d exp=0", out_level); else pass_cnt++;
        total_cnt++; if (ext_out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", ext_out_valid); else pass_cnt++;
        total_cnt++; if (ext_out_data !== '0) $display("FAIL mid_out_data got=%h exp=0", ext_out_data); else pass_cnt++;
        total_cnt++; if (ext_in_ready !== 1'b0) $display("FAIL mid_in_ready got=%b exp=0", ext_in_ready); else pass_cnt++;
        in_q.delete();
        out_q.delete();
        tick();
        rst = 1'b1;
        settle();
        tick();
        req_in = 1'b1;
        settle();
        total_cnt++; if (stall !== 1'b1) $display("FAIL mid_stale_stall got=%b exp=1", stall); else pass_cnt++;
        total_cnt++; if (io_in !== '0) $display("FAIL mid_stale_io_in got=%h exp=0", io_in); else pass_cnt++;
        total_cnt++; if (ext_out_valid !== 1'b0) $display("FAIL mid_stale_out_valid got=%b exp=0", ext_out_valid); else pass_cnt++;
        tick();
        req_in = 1'b0; ext_in_valid = 1'b1; ext_in_data = 32'h5A5A;
        in_q.push_back(ext_in_data);
        settle();
        tick();
        ext_in_valid = 1'b0; req_in = 1'b1;
        settle();
        exp = in_q.pop_front();
        total_cnt++; if (io_in !== exp) $display("FAIL mid_fresh_io_in got=%h exp=%h", io_in, exp); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL mid_fresh_stall got=%b exp=0", stall); else pass_cnt++;
        tick();
        idle_inputs();
        settle();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_in_order();
        test_in_empty_stall();
        test_out_full();
        test_wrap_concurrency();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
